// File: rtl/md_unit_pkg.sv
// Shared multiply/divide operation encodings and helpers for md_unit.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  // True for the four operations that occupy the unit for a fixed latency.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for the two divide operations, which use the longer latency.
  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Multiply/divide responder: latches a result on issue, holds busy for a fixed
// latency, then commits the result into the architectural HI/LO registers.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(DIV_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pending;

  logic        commit;
  logic        accept;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] safe_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic        div_zero;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // The commit edge frees the unit, so a new issue may be accepted on it.
  assign commit = busy && (cnt == '0);
  assign accept = start && is_arith(md_op) && (!busy || commit);

  // Result datapath: products, and division on sign-corrected magnitudes so
  // the quotient truncates toward zero and the remainder follows the dividend.
  always_comb begin
    prod_s   = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    prod_u   = {32'd0, rs_val} * {32'd0, rt_val};
    abs_a    = rs_val;
    abs_b    = rt_val;
    if (md_op == MD_DIV) begin
      abs_a = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
      abs_b = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
    end
    div_zero = (rt_val == 32'd0);
    safe_b   = div_zero ? 32'd1 : abs_b;
    q_mag    = abs_a / safe_b;
    r_mag    = abs_a % safe_b;
    div_q    = q_mag;
    div_r    = r_mag;
    if (md_op == MD_DIV) begin
      div_q = (rs_val[31] ^ rt_val[31]) ? (~q_mag + 32'd1) : q_mag;
      div_r = rs_val[31] ? (~r_mag + 32'd1) : r_mag;
    end
    res_hi = div_r;
    res_lo = div_q;
    if (md_op == MD_MULT) begin
      res_hi = prod_s[63:32];
      res_lo = prod_s[31:0];
    end else if (md_op == MD_MULTU) begin
      res_hi = prod_u[63:32];
      res_lo = prod_u[31:0];
    end
  end

  // Issue, countdown, commit and direct HI/LO writes; reset drops any op in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      cnt     <= '0;
      pending <= 1'b0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      if (busy && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (commit) begin
        busy <= 1'b0;
        if (pending) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end else if (!busy) begin
        if (md_op == MD_MTHI) begin
          hi <= rs_val;
        end else if (md_op == MD_MTLO) begin
          lo <= rs_val;
        end
      end
      if (accept) begin
        busy    <= 1'b1;
        cnt     <= is_div(md_op) ? DIV_LOAD : MUL_LOAD;
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pending <= !(is_div(md_op) && div_zero);
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: latency, results, direct writes, protocol
// violations, mid-operation reset and back-to-back issue at commit.
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int compared;
  int mismatched;

  md_unit #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs (called at a negedge), returns at the next negedge
  // with start cleared and md_op back to NONE.
  task automatic applyStimulus(input logic st, input md_op_e op,
                               input logic [31:0] a, input logic [31:0] b);
    start  = st;
    md_op  = op;
    rs_val = a;
    rt_val = b;
    @(negedge clk);
    start  = 1'b0;
    md_op  = MD_NONE;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Counts negedges on which busy is still high, bounded so a stuck unit
  // cannot hang the run.
  task automatic waitDone(input string tag, input int expected_cycles);
    int cycles;
    cycles = 0;
    while (busy && cycles < 50) begin
      cycles++;
      @(negedge clk);
    end
    checkOutput(tag, 64'(cycles), 64'(expected_cycles));
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    start      = 1'b0;
    md_op      = MD_NONE;
    rs_val     = 32'd0;
    rt_val     = 32'd0;
    idleCycles(3);
    reset = 1'b1;

    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_hilo", {hi, lo}, 64'd0);

    // MULT -2 * 3
    applyStimulus(1'b1, MD_MULT, 32'hFFFF_FFFE, 32'd3);
    checkOutput("mult_busy_first", 64'(busy), 64'd1);
    waitDone("mult_latency", 5);
    checkOutput("mult_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});

    // MULTU max * max
    applyStimulus(1'b1, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone("multu_latency", 5);
    checkOutput("multu_hilo", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});

    // DIV -7 / 2
    applyStimulus(1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2);
    waitDone("div_latency", 10);
    checkOutput("div_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    // DIVU by zero keeps HI/LO
    applyStimulus(1'b1, MD_DIVU, 32'd7, 32'd0);
    waitDone("divu0_latency", 10);
    checkOutput("divu0_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    // DIV overflow corner
    applyStimulus(1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone("divovf_latency", 10);
    checkOutput("divovf_hilo", {hi, lo}, {32'h0000_0000, 32'h8000_0000});

    // DIVU 100 / 7 -> q 14, r 2
    applyStimulus(1'b1, MD_DIVU, 32'd100, 32'd7);
    waitDone("divu_latency", 10);
    checkOutput("divu_hilo", {hi, lo}, {32'd2, 32'd14});

    // DIV 7 / -2 -> q -3, r 1
    applyStimulus(1'b1, MD_DIV, 32'd7, 32'hFFFF_FFFE);
    waitDone("div_negdivisor_latency", 10);
    checkOutput("div_negdivisor_hilo", {hi, lo}, {32'd1, 32'hFFFF_FFFD});

    // MTHI while idle, no start
    applyStimulus(1'b0, MD_MTHI, 32'h0000_1234, 32'd0);
    checkOutput("mthi_hi", {hi, lo}, {32'h0000_1234, 32'hFFFF_FFFD});
    applyStimulus(1'b0, MD_MTLO, 32'h0000_5678, 32'd0);
    checkOutput("mtlo_lo", {hi, lo}, {32'h0000_1234, 32'h0000_5678});

    // start with a non-arith op is ignored
    applyStimulus(1'b1, MD_NONE, 32'd9, 32'd9);
    checkOutput("start_none_busy", 64'(busy), 64'd0);
    checkOutput("start_none_hilo", {hi, lo}, {32'h0000_1234, 32'h0000_5678});

    // MTLO and a second start while busy are both ignored
    applyStimulus(1'b1, MD_MULT, 32'd6, 32'd7);
    applyStimulus(1'b0, MD_MTLO, 32'hDEAD_BEEF, 32'd0);
    checkOutput("mtlo_busy_lo", {hi, lo}, {32'h0000_1234, 32'h0000_5678});
    applyStimulus(1'b1, MD_MULTU, 32'd1, 32'd1);
    waitDone("second_start_latency", 3);
    checkOutput("second_start_hilo", {hi, lo}, {32'd0, 32'd42});

    // Reset on busy cycle 4 of a DIV drops it
    applyStimulus(1'b0, MD_MTHI, 32'h0000_0055, 32'd0);
    applyStimulus(1'b1, MD_DIVU, 32'd100, 32'd3);
    idleCycles(3);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    checkOutput("midreset_hilo", {hi, lo}, 64'd0);
    idleCycles(12);
    checkOutput("midreset_nocommit", {busy, hi, lo}, 65'd0);

    // Back-to-back issue on the commit edge
    applyStimulus(1'b1, MD_MULT, 32'd2, 32'd3);
    idleCycles(4);
    applyStimulus(1'b1, MD_MULT, 32'd4, 32'd5);
    checkOutput("b2b_first_hilo", {hi, lo}, {32'd0, 32'd6});
    checkOutput("b2b_busy", 64'(busy), 64'd1);
    waitDone("b2b_latency", 5);
    checkOutput("b2b_second_hilo", {hi, lo}, {32'd0, 32'd20});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
